// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU with a small registered flag latch.
//
// Result and flags are purely combinational from OP/R1/R2. The flag register
// is the only clocked logic. It captures OVERFLOW/ZF when FLAG_WE is high so
// that a later conditional branch can use them.
//
// Optional feature: define ALU_EXT_OPS_EN to enable the following opcodes:
//   101 SUB, 110 OR, 111 NOT
// Without the macro, opcodes 101-111 produce OUT=0, OVERFLOW=00, ZF=1.
//
// Ports:
//   CLK       in   clock, used only by the flag register
//   RST_N     in   asynchronous active-low reset of the flag register
//   OP        in   [2:0] operation select
//   R1        in   [WIDTH-1:0] operand 1 (low half for shifts)
//   R2        in   [WIDTH-1:0] operand 2 (high half for shifts)
//   FLAG_WE   in   capture OVERFLOW/ZF at the next CLK rising edge
//   OUT       out  [WIDTH-1:0] result (combinational)
//   OVERFLOW  out  [1:0] bit0 unsigned carry/borrow, bit1 signed overflow
//   ZF        out  1 when OUT == 0 (combinational)
//   OVF_R     out  [1:0] registered OVERFLOW
//   ZF_R      out  registered ZF

module alu_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] R1,
    input  logic [WIDTH-1:0] R2,
    input  logic             FLAG_WE,
    output logic [WIDTH-1:0] OUT,
    output logic [1:0]       OVERFLOW,
    output logic             ZF,
    output logic [1:0]       OVF_R,
    output logic             ZF_R
);

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpXor = 3'b001;
    localparam logic [2:0] OpShl = 3'b010;
    localparam logic [2:0] OpShr = 3'b011;
    localparam logic [2:0] OpAdd = 3'b100;
    localparam logic [2:0] OpSub = 3'b101;
    localparam logic [2:0] OpOr  = 3'b110;
    localparam logic [2:0] OpNot = 3'b111;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    // Adder widened by one bit so that the carry-out falls out directly.
    logic [WIDTH:0] add_sum;
    logic           add_carry;
    logic           add_sovf;

    always_comb begin
        add_sum   = {1'b0, R1} + {1'b0, R2};
        add_carry = add_sum[WIDTH];
        // Signed overflow: operands agree in sign, result sign differs.
        add_sovf  = (R1[WIDTH-1] == R2[WIDTH-1]) && (add_sum[WIDTH-1] != R1[WIDTH-1]);
    end

`ifdef ALU_EXT_OPS_EN
    // Widened subtractor: the top bit is set exactly when R1 < R2 unsigned.
    logic [WIDTH:0] sub_diff;
    logic           sub_borrow;
    logic           sub_sovf;

    always_comb begin
        sub_diff   = {1'b0, R1} - {1'b0, R2};
        sub_borrow = sub_diff[WIDTH];
        // Signed overflow: operand signs differ, result sign differs from R1.
        sub_sovf   = (R1[WIDTH-1] != R2[WIDTH-1]) && (sub_diff[WIDTH-1] != R1[WIDTH-1]);
    end
`endif

    // ------------------------------------------------------------------
    // Result / flag selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] result;
    logic [1:0]       ovf;

    always_comb begin
        result = '0;
        ovf    = 2'b00;
        case (OP)
            OpAnd: result = R1 & R2;
            OpXor: result = R1 ^ R2;
            // {R2,R1} << 1, keep the new high half.
            OpShl: result = {R2[WIDTH-2:0], R1[WIDTH-1]};
            // {R2,R1} >> 1, keep the new low half.
            OpShr: result = {R2[0], R1[WIDTH-1:1]};
            OpAdd: begin
                result = add_sum[WIDTH-1:0];
                ovf    = {add_sovf, add_carry};
            end
`ifdef ALU_EXT_OPS_EN
            OpSub: begin
                result = sub_diff[WIDTH-1:0];
                ovf    = {sub_sovf, sub_borrow};
            end
            OpOr:  result = R1 | R2;
            OpNot: result = ~R1;
`else
            // Reserved opcodes: a defined zero result.
            OpSub, OpOr, OpNot: begin
                result = '0;
                ovf    = 2'b00;
            end
`endif
            default: begin
                result = '0;
                ovf    = 2'b00;
            end
        endcase
    end

    assign OUT      = result;
    assign OVERFLOW = ovf;
    assign ZF       = (result == '0);

    // ------------------------------------------------------------------
    // Flag register
    // ------------------------------------------------------------------
    logic [1:0] ovf_d, ovf_q;
    logic       zf_d, zf_q;

    always_comb begin
        ovf_d = ovf_q;
        zf_d  = zf_q;
        if (FLAG_WE) begin
            ovf_d = ovf;
            zf_d  = (result == '0);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 2'b00;
            zf_q  <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            zf_q  <= zf_d;
        end
    end

    assign OVF_R = ovf_q;
    assign ZF_R  = zf_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (WIDTH = 8): directed vectors, randomized
// combinational checks against an arithmetic reference model, and the flag
// register (capture, hold, asynchronous reset, reset-over-write priority).
module tb_alu_core;

    logic       clk;
    logic       rst_n;
    logic [2:0] op;
    logic [7:0] r1;
    logic [7:0] r2;
    logic       flag_we;
    logic [7:0] out_w;
    logic [1:0] ovf_w;
    logic       zf_w;
    logic [1:0] ovf_r;
    logic       zf_r;

    int tests_run;
    int tests_failed;

    alu_core #(.WIDTH(8)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .OP       (op),
        .R1       (r1),
        .R2       (r2),
        .FLAG_WE  (flag_we),
        .OUT      (out_w),
        .OVERFLOW (ovf_w),
        .ZF       (zf_w),
        .OVF_R    (ovf_r),
        .ZF_R     (zf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic.
    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic void ref_alu(input int o, input int a, input int b,
                                    output int res, output int flg, output int z);
        int s;
        int ss;
        res = 0;
        flg = 0;
        case (o)
            0: res = a & b;
            1: res = a ^ b;
            2: res = ((b * 256 + a) * 2 / 256) % 256;
            3: res = ((b * 256 + a) / 2) % 256;
            4: begin
                s   = a + b;
                ss  = to_signed8(a) + to_signed8(b);
                res = s % 256;
                flg = ((ss > 127 || ss < -128) ? 2 : 0) + ((s > 255) ? 1 : 0);
            end
`ifdef ALU_EXT_OPS_EN
            5: begin
                ss  = to_signed8(a) - to_signed8(b);
                res = (a - b + 256) % 256;
                flg = ((ss > 127 || ss < -128) ? 2 : 0) + ((a < b) ? 1 : 0);
            end
            6: res = a | b;
            7: res = 255 - a;
`endif
            default: res = 0;
        endcase
        z = (res == 0) ? 1 : 0;
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        flag_we = 1'b1;
        op      = 3'd4;
        r1      = 8'hC8;
        r2      = 8'h38;
        @(posedge clk);
        #1;
        // Reset held with FLAG_WE high: reset must win.
        tests_run++;
        if (ovf_r !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ovf_r: got %b expected 00", ovf_r);
        end
        tests_run++;
        if (zf_r !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_zf_r: got %b expected 0", zf_r);
        end
        flag_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [2:0] d_op  [11];
    logic [7:0] d_a   [11];
    logic [7:0] d_b   [11];
    logic [7:0] d_out [11];
    logic [1:0] d_ovf [11];
    logic       d_zf  [11];

    task automatic test_directed();
        d_op  = '{3'd0,  3'd1,  3'd2,  3'd3,  3'd3,  3'd4,  3'd4,  3'd4,  3'd4,  3'd5,  3'd7};
        d_a   = '{8'hAA, 8'hAA, 8'h80, 8'h01, 8'h02, 8'h10, 8'h7F, 8'hFF, 8'hC8, 8'h05, 8'hAA};
        d_b   = '{8'hCC, 8'hCC, 8'h0F, 8'hF0, 8'h01, 8'h20, 8'h01, 8'h02, 8'h38, 8'h06, 8'hCC};
        d_out = '{8'h88, 8'h66, 8'h1F, 8'h00, 8'h81, 8'h30, 8'h80, 8'h01, 8'h00,
`ifdef ALU_EXT_OPS_EN
                  8'hFF, 8'h55};
`else
                  8'h00, 8'h00};
`endif
        d_ovf = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01,
`ifdef ALU_EXT_OPS_EN
                  2'b01, 2'b00};
`else
                  2'b00, 2'b00};
`endif
        d_zf  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
`ifdef ALU_EXT_OPS_EN
                  1'b0, 1'b0};
`else
                  1'b1, 1'b1};
`endif
        for (int i = 0; i < 11; i++) begin
            op = d_op[i];
            r1 = d_a[i];
            r2 = d_b[i];
            #1;
            tests_run++;
            if (out_w !== d_out[i] || ovf_w !== d_ovf[i] || zf_w !== d_zf[i]) begin
                tests_failed++;
                $display("FAIL directed_%0d op=%0d a=%h b=%h: got out=%h ovf=%b zf=%b expected out=%h ovf=%b zf=%b",
                         i, op, r1, r2, out_w, ovf_w, zf_w, d_out[i], d_ovf[i], d_zf[i]);
            end
        end
    endtask

    task automatic test_random_comb();
        int e_out, e_ovf, e_zf;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            r1 = 8'($urandom_range(0, 255));
            r2 = 8'($urandom_range(0, 255));
            // Bias some ADDs toward the wrap/overflow edges.
            if (i % 10 == 0) begin
                op = 3'd4;
                r2 = 8'(256 - int'(r1));
            end
            #1;
            ref_alu(int'(op), int'(r1), int'(r2), e_out, e_ovf, e_zf);
            tests_run++;
            if (out_w !== 8'(e_out) || ovf_w !== 2'(e_ovf) || zf_w !== 1'(e_zf)) begin
                tests_failed++;
                $display("FAIL random_comb op=%0d a=%h b=%h: got out=%h ovf=%b zf=%b expected out=%h ovf=%b zf=%b",
                         op, r1, r2, out_w, ovf_w, zf_w, 8'(e_out), 2'(e_ovf), 1'(e_zf));
            end
        end
    endtask

    task automatic test_flag_reg();
        @(negedge clk);
        op      = 3'd4;
        r1      = 8'd200;
        r2      = 8'd56;
        flag_we = 1'b1;
        @(posedge clk);
        #1;
        flag_we = 1'b0;
        tests_run++;
        if (zf_r !== 1'b1 || ovf_r !== 2'b01) begin
            tests_failed++;
            $display("FAIL flag_capture: got ovf_r=%b zf_r=%b expected 01 1", ovf_r, zf_r);
        end
        r1 = 8'h10;
        r2 = 8'h20;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (zf_r !== 1'b1 || ovf_r !== 2'b01) begin
            tests_failed++;
            $display("FAIL flag_hold: got ovf_r=%b zf_r=%b expected 01 1", ovf_r, zf_r);
        end
        // Asynchronous clear between edges.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (zf_r !== 1'b0 || ovf_r !== 2'b00) begin
            tests_failed++;
            $display("FAIL flag_async_reset: got ovf_r=%b zf_r=%b expected 00 0", ovf_r, zf_r);
        end
        rst_n = 1'b1;
        // Second capture: signed overflow.
        @(negedge clk);
        r1      = 8'h7F;
        r2      = 8'h01;
        flag_we = 1'b1;
        @(posedge clk);
        #1;
        flag_we = 1'b0;
        tests_run++;
        if (zf_r !== 1'b0 || ovf_r !== 2'b10) begin
            tests_failed++;
            $display("FAIL flag_capture_sovf: got ovf_r=%b zf_r=%b expected 10 0", ovf_r, zf_r);
        end
    endtask

    task automatic test_random_flags();
        int e_out, e_ovf, e_zf;
        int m_ovf, m_zf;
        m_ovf = int'(ovf_r === 2'b10 ? 2 : 0);
        m_zf  = 0;
        // Start from a known state.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_ovf = 0;
        m_zf  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            op      = 3'($urandom_range(0, 7));
            r1      = 8'($urandom_range(0, 255));
            r2      = 8'($urandom_range(0, 255));
            flag_we = 1'($urandom_range(0, 1));
            ref_alu(int'(op), int'(r1), int'(r2), e_out, e_ovf, e_zf);
            if (flag_we) begin
                m_ovf = e_ovf;
                m_zf  = e_zf;
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (ovf_r !== 2'(m_ovf) || zf_r !== 1'(m_zf)) begin
                tests_failed++;
                $display("FAIL random_flags op=%0d a=%h b=%h we=%b: got ovf_r=%b zf_r=%b expected %b %b",
                         op, r1, r2, flag_we, ovf_r, zf_r, 2'(m_ovf), 1'(m_zf));
            end
        end
        flag_we = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        flag_we      = 1'b0;
        op           = 3'd0;
        r1           = 8'h00;
        r2           = 8'h00;
        test_reset();
        test_directed();
        test_random_comb();
        test_flag_reg();
        test_random_flags();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
